// File: rtl/sub_arb_pkg.sv
// sub_arb_pkg: shared FSM state type and flag-vector bit positions for sub_arbiter.
package sub_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      CAPTURE,
      RESP
   } state_t;

   localparam int FLG_COUT = 3;
   localparam int FLG_NEG  = 2;
   localparam int FLG_ZERO = 1;
   localparam int FLG_OVF  = 0;

endpackage

// File: rtl/sub_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker; the search starts at ptr and
// wraps modulo NREQ, returning a one-hot grant plus the winner's binary id.
module rr_arbiter #(
   parameter  int NREQ = 4,
   localparam int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   input  logic            en,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  id
);

   int   idx;
   logic found;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path infers a latch.
      grant = '0;
      id    = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(ptr) + k) % NREQ;
         if (en && !found && req[idx]) begin
            grant[idx] = 1'b1;
            id         = IDW'(idx);
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sub_arbiter.sv
// sub_arbiter: time-shares one external subtractor among NREQ requesters.
// Optional build macro SUB_ARB_STATS_EN adds op_count and stall_count outputs.
module sub_arbiter
   import sub_arb_pkg::*;
#(
   parameter int N    = 32,
   parameter int NREQ = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ*N-1:0] req_a,
   input  logic [NREQ*N-1:0] req_b,
   output logic [NREQ-1:0]   req_ready,
   output logic [N-1:0]      sub_a,
   output logic [N-1:0]      sub_b,
   input  logic [N-1:0]      sub_z,
   input  logic              sub_cout,
   input  logic              sub_neg,
   input  logic              sub_zero,
   input  logic              sub_ovf,
   output logic [NREQ-1:0]   resp_valid,
   input  logic [NREQ-1:0]   resp_ready,
   output logic [N-1:0]      resp_z,
   output logic [3:0]        resp_flags,
   output logic              busy
`ifdef SUB_ARB_STATS_EN
   ,
   output logic [31:0]       op_count,
   output logic [31:0]       stall_count
`endif
);

   localparam int IDW = $clog2(NREQ);

   state_t          state, state_nxt;
   logic [IDW-1:0]  ptr;
   logic [IDW-1:0]  owner;
   logic [IDW-1:0]  grant_id;
   logic [NREQ-1:0] grant;
   logic            arb_en;
   logic            accept;
   logic            resp_done;
   logic [3:0]      sub_flags;

   // Gating with rst keeps req_ready at 0 while reset is held, like every other output.
   assign arb_en    = (state == IDLE) && !rst;
   assign req_ready = grant;
   assign accept    = |(req_valid & grant);
   assign resp_done = (state == RESP) && resp_ready[owner];

   rr_arbiter #(.NREQ(NREQ)) u_rr (
      .req   (req_valid),
      .ptr   (ptr),
      .en    (arb_en),
      .grant (grant),
      .id    (grant_id)
   );

   always_comb begin
      sub_flags           = '0;
      sub_flags[FLG_COUT] = sub_cout;
      sub_flags[FLG_NEG]  = sub_neg;
      sub_flags[FLG_ZERO] = sub_zero;
      sub_flags[FLG_OVF]  = sub_ovf;
   end

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b1;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (accept) state_nxt = SETTLE;
         end
         SETTLE:  state_nxt = CAPTURE;
         CAPTURE: state_nxt = RESP;
         RESP:    if (resp_ready[owner]) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr        <= '0;
         owner      <= '0;
         sub_a      <= '0;
         sub_b      <= '0;
         resp_z     <= '0;
         resp_flags <= '0;
         resp_valid <= '0;
      end else begin
         if (accept) begin
            sub_a <= req_a[int'(grant_id)*N +: N];
            sub_b <= req_b[int'(grant_id)*N +: N];
            owner <= grant_id;
            ptr   <= (int'(grant_id) == NREQ-1) ? '0 : grant_id + IDW'(1);
         end
         // Result and flags are sampled together, one full cycle after operands settle.
         if (state == CAPTURE) begin
            resp_z     <= sub_z;
            resp_flags <= sub_flags;
            resp_valid <= NREQ'(1) << owner;
         end
         if (resp_done) resp_valid <= '0;
      end
   end

`ifdef SUB_ARB_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_count    <= '0;
         stall_count <= '0;
      end else begin
         if (resp_done) op_count <= op_count + 32'd1;
         if ((state == RESP) && !resp_ready[owner] && (stall_count != '1))
            stall_count <= stall_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_sub_arbiter.sv
// tb_sub_arbiter: directed plus randomized bench comparing sub_arbiter against a
// transaction-level model driven by the arbitration and response rules.
module tb_sub_arbiter;
   import sub_arb_pkg::*;

   localparam int N    = 32;
   localparam int NREQ = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ*N-1:0] req_a, req_b;
   logic [NREQ-1:0]   req_ready;
   logic [N-1:0]      sub_a, sub_b, sub_z;
   logic              sub_cout, sub_neg, sub_zero, sub_ovf;
   logic [NREQ-1:0]   resp_valid;
   logic [NREQ-1:0]   resp_ready;
   logic [N-1:0]      resp_z;
   logic [3:0]        resp_flags;
   logic              busy;
`ifdef SUB_ARB_STATS_EN
   logic [31:0]       op_count, stall_count;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   sub_arbiter #(.N(N), .NREQ(NREQ)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_ready  (req_ready),
      .sub_a      (sub_a),
      .sub_b      (sub_b),
      .sub_z      (sub_z),
      .sub_cout   (sub_cout),
      .sub_neg    (sub_neg),
      .sub_zero   (sub_zero),
      .sub_ovf    (sub_ovf),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_z     (resp_z),
      .resp_flags (resp_flags),
      .busy       (busy)
`ifdef SUB_ARB_STATS_EN
      ,
      .op_count   (op_count),
      .stall_count(stall_count)
`endif
   );

   // Reference subtractor: returns {cout, neg, zero, ovf, z}; cout is the carry of a + ~b + 1.
   function automatic logic [N+3:0] sub_ref(input logic [N-1:0] a, input logic [N-1:0] b);
      logic [N:0]   full;
      logic [N-1:0] z;
      logic         ovf;
      full = {1'b0, a} + {1'b0, ~b} + (N+1)'(1);
      z    = full[N-1:0];
      ovf  = (a[N-1] != b[N-1]) && (z[N-1] != a[N-1]);
      return {full[N], z[N-1], (z == '0), ovf, z};
   endfunction

   logic [N+3:0] sub_out;
   assign sub_out = sub_ref(sub_a, sub_b);
   assign sub_z   = sub_out[N-1:0];
   assign {sub_cout, sub_neg, sub_zero, sub_ovf} = sub_out[N+3:N];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: m_age is cycles since accept (-1 when no operation is in flight).
   int              m_age = -1;
   int              m_ptr = 0;
   int              m_owner = 0;
   logic [N-1:0]    m_a = '0, m_b = '0, m_z = '0;
   logic [3:0]      m_flags = '0;
   logic [31:0]     m_ops = '0, m_stall = '0;
   int              m_wait [NREQ];
   int              g;
   logic [NREQ-1:0] exp_ready, exp_rv;

   always @(negedge clk) begin
      if (rst) begin
         check("rst_req_ready", req_ready, '0);
         check("rst_busy", busy, 0);
         check("rst_sub_a", sub_a, '0);
         check("rst_sub_b", sub_b, '0);
         check("rst_resp_valid", resp_valid, '0);
         check("rst_resp_z", resp_z, '0);
         check("rst_resp_flags", resp_flags, '0);
         m_age = -1; m_ptr = 0; m_owner = 0;
         m_a = '0; m_b = '0; m_z = '0; m_flags = '0;
         m_ops = '0; m_stall = '0;
         for (int i = 0; i < NREQ; i++) m_wait[i] = 0;
      end else begin
         g = -1;
         if (m_age < 0)
            for (int k = 0; k < NREQ; k++)
               if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
         exp_ready = '0;
         if (g >= 0) exp_ready[g] = 1'b1;
         exp_rv = '0;
         if (m_age >= 3) exp_rv[m_owner] = 1'b1;

         check("req_ready", req_ready, exp_ready);
         check("busy", busy, (m_age >= 0));
         check("sub_a", sub_a, m_a);
         check("sub_b", sub_b, m_b);
         check("resp_valid", resp_valid, exp_rv);
         check("resp_z", resp_z, m_z);
         check("resp_flags", resp_flags, m_flags);
`ifdef SUB_ARB_STATS_EN
         check("op_count", op_count, m_ops);
         check("stall_count", stall_count, m_stall);
`endif

         for (int i = 0; i < NREQ; i++) if (!req_valid[i]) m_wait[i] = 0;
         if (m_age < 0) begin
            if (g >= 0) begin
               check("fair_wait", (m_wait[g] < NREQ), 1);
               for (int i = 0; i < NREQ; i++) if (i != g && req_valid[i]) m_wait[i]++;
               m_wait[g] = 0;
               m_age     = 1;
               m_owner   = g;
               m_a       = req_a[g*N +: N];
               m_b       = req_b[g*N +: N];
               m_ptr     = (g + 1) % NREQ;
            end
         end else if (m_age == 1) begin
            m_age = 2;
         end else if (m_age == 2) begin
            {m_flags, m_z} = sub_ref(m_a, m_b);
            m_age = 3;
         end else if (resp_ready[m_owner]) begin
            m_age = -1;
            m_ops = m_ops + 32'd1;
         end else if (m_stall != 32'hFFFF_FFFF) begin
            m_stall = m_stall + 32'd1;
            m_age++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_grant(output int id);
      id = -1;
      for (int c = 0; c < 40 && id < 0; c++) begin
         @(negedge clk);
         for (int i = 0; i < NREQ; i++) if (req_ready[i]) id = i;
      end
      check("grant_seen", (id >= 0), 1);
   endtask

   task automatic wait_resp();
      logic seen = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
         @(negedge clk);
         seen = (resp_valid != '0);
      end
      check("resp_seen", seen, 1);
   endtask

   task automatic wait_idle();
      logic idle = 1'b0;
      for (int c = 0; c < 60 && !idle; c++) begin
         @(negedge clk);
         idle = !busy;
      end
      check("idle_seen", idle, 1);
   endtask

   function automatic logic [N-1:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return 32'h8000_0000;
         2:       return 32'h7FFF_FFFF;
         3:       return 32'hFFFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   int id;

   initial begin
      req_valid  = '0;
      req_a      = '0;
      req_b      = '0;
      resp_ready = '0;

      // All four requesters valid from reset: grants rotate 0,1,2,3,0.
      for (int i = 0; i < NREQ; i++) begin
         req_a[i*N +: N] = 32'(100 * (i + 1));
         req_b[i*N +: N] = 32'(i + 1);
      end
      req_valid  = '1;
      resp_ready = '1;
      repeat (3) tick();
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         wait_grant(id);
         check("rr_order", id, k % NREQ);
      end
      tick();
      req_valid = '0;
      wait_idle();

      // Single request from requester 1: 10 - 3, response three cycles after accept.
      tick();
      req_a[1*N +: N] = 32'd10;
      req_b[1*N +: N] = 32'd3;
      req_valid       = 4'b0010;
      wait_grant(id);
      check("single_id", id, 1);
      tick();
      req_valid = '0;
      @(negedge clk); check("lat_cycle1", resp_valid, 4'b0000);
      @(negedge clk); check("lat_cycle2", resp_valid, 4'b0000);
      @(negedge clk); check("lat_cycle3", resp_valid, 4'b0010);
      check("single_z", resp_z, 32'd7);
      check("single_flags", resp_flags, 4'b1000);
      wait_idle();

      // ptr=2 with requesters 0 and 3 valid picks 3; 0x80000000 - 1 overflows.
      tick();
      req_a[3*N +: N] = 32'h8000_0000;
      req_b[3*N +: N] = 32'd1;
      req_valid       = 4'b1001;
      wait_grant(id);
      check("ptr2_grant", id, 3);
      tick();
      req_valid = '0;
      wait_resp();
      check("ovf_z", resp_z, 32'h7FFF_FFFF);
      check("ovf_flags", resp_flags, 4'b1001);
      wait_idle();

      // Fresh reset, then backpressure with wrong-owner resp_ready on owner 2 (5 - 5).
      tick();
      rst = 1'b1;
      tick();
      rst             = 1'b0;
      req_a[2*N +: N] = 32'd5;
      req_b[2*N +: N] = 32'd5;
      req_valid       = 4'b0100;
      resp_ready      = 4'b0001;
      wait_grant(id);
      check("bp_grant", id, 2);
      tick();
      req_valid = 4'b1001;
      wait_resp();
      for (int k = 0; k < 5; k++) begin
         if (k > 0) @(negedge clk);
         check("bp_resp_valid", resp_valid, 4'b0100);
         check("bp_resp_z", resp_z, 32'd0);
         check("bp_flags", resp_flags, 4'b1010);
         check("bp_busy", busy, 1);
         check("bp_no_grant", req_ready, 4'b0000);
      end
      tick();
      resp_ready = 4'b0100;
      @(negedge clk);
      check("bp_release_valid", resp_valid, 4'b0100);
      @(negedge clk);
      check("bp_after_grant", req_ready, 4'b1000);
`ifdef SUB_ARB_STATS_EN
      check("bp_op_count", op_count, 32'd1);
      check("bp_stall_count", stall_count, 32'd5);
`endif
      tick();
      req_valid  = '0;
      resp_ready = '1;
      wait_idle();

      // Reset during SETTLE discards the operation and returns the pointer to 0.
      tick();
      req_valid = 4'b0010;
      wait_grant(id);
      check("pre_rst_grant", id, 1);
      tick();
      check("in_settle", busy, 1);
      rst = 1'b1;
      #1;
      check("rst_mid_busy", busy, 0);
      check("rst_mid_sub_a", sub_a, '0);
      check("rst_mid_resp_valid", resp_valid, '0);
      check("rst_mid_req_ready", req_ready, '0);
      tick();
      rst       = 1'b0;
      req_valid = 4'b0011;
      wait_grant(id);
      check("post_rst_grant", id, 0);
      tick();
      req_valid = '0;
      wait_idle();

      // Randomized traffic, backpressure and occasional resets.
      for (int c = 0; c < 3000; c++) begin
         tick();
         rst        = ($urandom_range(0, 299) == 0);
         req_valid  = NREQ'($urandom);
         resp_ready = NREQ'($urandom) | (($urandom_range(0, 1) == 0) ? '1 : '0);
         for (int i = 0; i < NREQ; i++) begin
            req_a[i*N +: N] = pick_operand();
            req_b[i*N +: N] = ($urandom_range(0, 7) == 0) ? req_a[i*N +: N] : pick_operand();
         end
      end

      tick();
      rst        = 1'b0;
      req_valid  = '0;
      resp_ready = '1;
      wait_idle();
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/sub_arbiter.md
Name: sub_arbiter

Overview:
- Time-shares one external n-bit subtractor datapath among NREQ requesters, e.g. filter pipelines needing pixel differences.
- Round-robin arbitration, registered operand issue, result and flag capture.
- Per-requester valid/ready request and response handshakes.
- Sits between the image-filter engines and the single subtractor instance in the ALU.

Parameters:
N, 32, operand/result width; must match the shared subtractor instance.
NREQ, 4, number of requesters (2..8).
IDW, $clog2(NREQ), requester id width (derived, not overridden).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
req_valid  in  NREQ  per-requester request valid.
req_a  in  NREQ*N  packed minuend operands; requester i occupies bits [i*N +: N].
req_b  in  NREQ*N  packed subtrahend operands, same packing.
req_ready  out  NREQ  one-hot grant; request i accepted when req_valid[i] & req_ready[i].
sub_a  out  N  operand A to shared subtractor (registered).
sub_b  out  N  operand B to shared subtractor (registered).
sub_z  in  N  subtractor result (combinational from sub_a/sub_b).
sub_cout  in  1  subtractor carry/borrow out.
sub_neg  in  1  negative flag.
sub_zero  in  1  zero flag.
sub_ovf  in  1  overflow flag.
resp_valid  out  NREQ  one-hot response valid to the owning requester.
resp_ready  in  NREQ  per-requester response accept.
resp_z  out  N  captured result.
resp_flags  out  4  {cout, neg, zero, ovf}, captured together with resp_z.
busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: all outputs 0, state IDLE, round-robin pointer 0.
- FSM states:
  - IDLE: req_ready = one-hot grant of the highest-priority valid requester, combinational.
    - Priority search starts at ptr and wraps modulo NREQ.
    - On handshake: latch req_a/req_b into sub_a/sub_b, latch owner id, ptr <= (id+1) mod NREQ, go to SETTLE.
    - No valid request: stay in IDLE, req_ready = 0.
  - SETTLE: one cycle for the ripple-carry path to resolve; sub_a/sub_b held stable; req_ready = 0. Go to CAPTURE.
  - CAPTURE: register sub_z and flags into resp_z/resp_flags; set resp_valid[owner]. Go to RESP.
  - RESP: hold resp_valid, resp_z and resp_flags stable until resp_ready[owner]=1. Then clear resp_valid and go to IDLE.
    - resp_ready of non-owners is ignored.
- Latency: accept edge to resp_valid high = 3 cycles (accept, SETTLE, CAPTURE).
- Throughput: one operation per 4 cycles minimum. IDLE re-arbitrates only after the response is consumed; there is no overlap.
- sub_a/sub_b keep their last value outside SETTLE/CAPTURE; no forced zeroing.
- Fairness:
  - A requester that holds valid is granted within NREQ operations.
  - A requester that drops valid before being granted loses its turn silently.
- req_ready is one-hot or zero and never asserted outside IDLE.
- Arithmetic: this block does no arithmetic. Results and flags pass through bit-exact; width is N throughout.
- Reset mid-operation: the in-flight op is discarded with no response, state returns to IDLE, ptr returns to 0.
- Simultaneous requests: exactly one grant per IDLE cycle. Example: ptr=2 with requests 0 and 3 valid → grant 3.

Optional Feature:
- Macro: SUB_ARB_STATS_EN.
- Defined:
  - Adds output op_count (32 bit, increments on each response handshake, wraps at 2^32).
  - Adds output stall_count (32 bit, increments each cycle in RESP with resp_ready[owner]=0, saturates at all-ones).
  - Both counters reset to 0.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- Shared package sub_arb_pkg:
  - state enum typedef {IDLE, SETTLE, CAPTURE, RESP}.
  - flag-vector index constants FLG_COUT=3, FLG_NEG=2, FLG_ZERO=1, FLG_OVF=0.
- One sub-module: rr_arbiter, parameterised on NREQ.
  - Inputs: request vector, pointer, enable.
  - Output: one-hot grant and binary id; purely combinational.

Test Plan:
- Single request: requester 1 sends A=10, B=3. req_ready[1] pulses one cycle; resp_valid[1] is high exactly 3 cycles after accept; resp_z and flags equal the subtractor model output for 10-3.
- All four requesters valid continuously from reset: grants follow order 0,1,2,3,0. Each resp_valid reaches only its owner; no requester waits more than 4 operations.
- Response backpressure: resp_ready held low 5 cycles. resp_z/flags remain stable; no new grant is issued; with STATS, stall_count=5 and op_count=1 after release.
- Flag pass-through: A=5, B=5 yields resp_flags[FLG_ZERO]=1. A=0x80000000, B=1 yields resp_flags[FLG_OVF] equal to the model.
- Reset asserted during SETTLE: all outputs 0 immediately; no resp_valid after release; next grant goes to requester 0.
- Wrong-owner resp_ready: owner 2 in RESP, resp_ready=4'b0001. resp_valid[2] stays high and the state stays RESP.
